// File: rtl/wrp_shff_fifo_in_if.sv
// Handshake bundle between the upstream sync FIFO, the shuffle-buffer write
// port and the downstream block reader.
interface wrp_shff_fifo_in_if;
  logic        fifo_empty;
  logic        fifo_re;
  logic [63:0] fifo_rd;
  logic        buf_we;
  logic [13:0] buf_wa;
  logic [63:0] buf_wd;
  logic        buf_empty;
  logic        buf_rdone;
  logic        buf_full;
  logic        err_udf;

  // The writer block drives the FIFO read strobe and the buffer write port.
  modport master (
    input  fifo_empty, fifo_rd, buf_rdone,
    output fifo_re, buf_we, buf_wa, buf_wd, buf_empty, buf_full, err_udf
  );

  modport slave (
    output fifo_empty, fifo_rd, buf_rdone,
    input  fifo_re, buf_we, buf_wa, buf_wd, buf_empty, buf_full, err_udf
  );
endinterface

// File: rtl/wrp_shff_fifo_in.sv
// Moves 16-word blocks from a sync FIFO into a 1024-block shuffle buffer,
// transposing the block address on alternate 1024-block frames.
module wrp_shff_fifo_in #(
  parameter int fifo_delay = 1
) (
  input  logic                clk,
  input  logic                srst,
  wrp_shff_fifo_in_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t                state, state_nx;
  logic [10:0]           blk_cnt;
  logic [10:0]           wa_cnt;
  logic [4:0]            icnt;
  logic [4:0]            wcnt;
  logic [fifo_delay-1:0] vpipe;
  logic                  re;
  logic                  commit;
  logic                  we_q;
  logic [13:0]           wa_q;
  logic [63:0]           wd_q;
  logic                  err_q;
  logic [9:0]            wa_msb;

  assign wa_msb = wa_cnt[10] ? {wa_cnt[4:0], wa_cnt[9:5]} : wa_cnt[9:0];

  // Commit one cycle after the 16th write is presented, so the reader never
  // sees a block whose last word is still in flight.
  assign commit = (state == DRAIN) && wcnt[4] && !we_q;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_nx = state;
    re       = 1'b0;
    case (state)
      IDLE:  if (blk_cnt != 11'd1024 && !bus.fifo_empty) state_nx = FILL;
      FILL: begin
        re = !bus.fifo_empty;
        if (re && icnt == 5'd15) state_nx = DRAIN;
      end
      DRAIN: if (commit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      vpipe  <= '0;
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      icnt   <= '0;
      wcnt   <= '0;
      wa_cnt <= '0;
    end else begin
      vpipe <= (vpipe << 1) | fifo_delay'(re);
      we_q  <= vpipe[fifo_delay-1];
      if (vpipe[fifo_delay-1]) begin
        wd_q <= bus.fifo_rd;
        wa_q <= {wa_msb, wcnt[3:0]};
        wcnt <= wcnt + 5'd1;
      end
      if (re) icnt <= icnt + 5'd1;
      if (commit) begin
        icnt   <= '0;
        wcnt   <= '0;
        wa_cnt <= wa_cnt + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      blk_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (commit && !bus.buf_rdone)
        blk_cnt <= blk_cnt + 11'd1;
      else if (!commit && bus.buf_rdone && blk_cnt != 11'd0)
        blk_cnt <= blk_cnt - 11'd1;
      if (bus.buf_rdone && blk_cnt == 11'd0) err_q <= 1'b1;
    end
  end

  assign bus.fifo_re   = re;
  assign bus.buf_we    = we_q;
  assign bus.buf_wa    = wa_q;
  assign bus.buf_wd    = wd_q;
  assign bus.buf_empty = (blk_cnt == 11'd0);
  assign bus.buf_full  = (blk_cnt == 11'd1024);
  assign bus.err_udf   = err_q;

endmodule

// File: tb/tb_wrp_shff_fifo_in.sv
// Directed bench for wrp_shff_fifo_in: FIFO model, write logger and one task
// per scenario with hand-derived expectations.
module tb_wrp_shff_fifo_in;

  logic clk  = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  wrp_shff_fifo_in_if bus();
  wrp_shff_fifo_in #(.fifo_delay(1)) dut (.clk(clk), .srst(srst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int pushed = 0;
  int popped = 0;
  int wa_k   = 0;
  logic [63:0] rd_q  = '0;
  logic        rdone = 1'b0;

  assign bus.fifo_empty = (pushed == popped);
  assign bus.fifo_rd    = rd_q;
  assign bus.buf_rdone  = rdone;

  function automatic logic [63:0] word(int n);
    logic [31:0] u;
    u = 32'(n);
    return {u ^ 32'hDEAD_BEEF, u};
  endfunction

  function automatic logic [13:0] base(int k);
    logic [10:0] w;
    logic [9:0]  m;
    w = 11'(k);
    m = w[10] ? {w[4:0], w[9:5]} : w[9:0];
    return {m, 4'h0};
  endfunction

  // One-cycle read latency FIFO model
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_re && !bus.fifo_empty) begin
      popped <= popped + 1;
      rd_q   <= word(popped);
    end
  end

  typedef struct {
    int          c;
    logic [13:0] wa;
    logic [63:0] wd;
  } wr_t;
  wr_t log_q[$];

  always @(negedge clk)
    if (bus.buf_we === 1'b1) log_q.push_back('{cyc, bus.buf_wa, bus.buf_wd});

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    srst = 1'b1;
    step(2);
    n_vec++; if (bus.fifo_re   !== 1'b0)  begin n_err++; $display("FAIL rst_fifo_re got %b want 0", bus.fifo_re); end
    n_vec++; if (bus.buf_we    !== 1'b0)  begin n_err++; $display("FAIL rst_buf_we got %b want 0", bus.buf_we); end
    n_vec++; if (bus.buf_wa    !== 14'h0) begin n_err++; $display("FAIL rst_buf_wa got %h want 0", bus.buf_wa); end
    n_vec++; if (bus.buf_wd    !== 64'h0) begin n_err++; $display("FAIL rst_buf_wd got %h want 0", bus.buf_wd); end
    n_vec++; if (bus.buf_empty !== 1'b1)  begin n_err++; $display("FAIL rst_buf_empty got %b want 1", bus.buf_empty); end
    n_vec++; if (bus.buf_full  !== 1'b0)  begin n_err++; $display("FAIL rst_buf_full got %b want 0", bus.buf_full); end
    n_vec++; if (bus.err_udf   !== 1'b0)  begin n_err++; $display("FAIL rst_err_udf got %b want 0", bus.err_udf); end
    srst = 1'b0;
    step(3);
  endtask

  // 16 words pushed in cycle c0: reads c0+1..c0+16, writes c0+3..c0+18, empty falls c0+20
  task automatic test_single_block;
    int s0, c0;
    log_q.delete();
    s0 = popped;
    c0 = cyc;
    pushed += 16;
    step(19);
    n_vec++; if (bus.buf_empty !== 1'b1) begin n_err++; $display("FAIL blk_empty_before got %b want 1", bus.buf_empty); end
    step(1);
    n_vec++; if (bus.buf_empty !== 1'b0) begin n_err++; $display("FAIL blk_empty_after got %b want 0", bus.buf_empty); end
    step(5);
    n_vec++; if (log_q.size() != 16) begin n_err++; $display("FAIL blk_count got %0d want 16", log_q.size()); end
    for (int i = 0; i < log_q.size() && i < 16; i++) begin
      n_vec++;
      if (log_q[i].c != c0 + 3 + i || log_q[i].wa !== 14'(i) || log_q[i].wd !== word(s0 + i)) begin
        n_err++;
        $display("FAIL blk_wr%0d got cyc %0d wa %h wd %h want cyc %0d wa %h wd %h",
                 i, log_q[i].c, log_q[i].wa, log_q[i].wd, c0 + 3 + i, 14'(i), word(s0 + i));
      end
    end
    wa_k++;
  endtask

  task automatic test_stall;
    int s0;
    logic [13:0] b;
    log_q.delete();
    s0 = popped;
    b  = base(wa_k);
    pushed += 7;
    step(20);
    n_vec++; if (log_q.size() != 7) begin n_err++; $display("FAIL stall_partial got %0d want 7", log_q.size()); end
    n_vec++; if (bus.fifo_re !== 1'b0) begin n_err++; $display("FAIL stall_re got %b want 0", bus.fifo_re); end
    pushed += 9;
    step(40);
    n_vec++; if (log_q.size() != 16) begin n_err++; $display("FAIL stall_count got %0d want 16", log_q.size()); end
    for (int i = 0; i < log_q.size() && i < 16; i++) begin
      n_vec++;
      if (log_q[i].wa !== b + 14'(i) || log_q[i].wd !== word(s0 + i)) begin
        n_err++;
        $display("FAIL stall_wr%0d got wa %h wd %h want wa %h wd %h",
                 i, log_q[i].wa, log_q[i].wd, b + 14'(i), word(s0 + i));
      end
    end
    n_vec++; if (bus.buf_empty !== 1'b0) begin n_err++; $display("FAIL stall_empty got %b want 0", bus.buf_empty); end
    wa_k++;
  endtask

  // Enters with two committed blocks.
  task automatic test_counts;
    int c0;
    rdone = 1'b1; step(1); rdone = 1'b0;
    n_vec++; if (bus.buf_empty !== 1'b0) begin n_err++; $display("FAIL cnt_one_left got %b want 0", bus.buf_empty); end
    step(1);
    rdone = 1'b1; step(1); rdone = 1'b0;
    n_vec++; if (bus.buf_empty !== 1'b1) begin n_err++; $display("FAIL cnt_zero got %b want 1", bus.buf_empty); end
    n_vec++; if (bus.err_udf !== 1'b0) begin n_err++; $display("FAIL cnt_no_udf got %b want 0", bus.err_udf); end
    step(1);
    rdone = 1'b1; step(1); rdone = 1'b0;
    n_vec++; if (bus.err_udf !== 1'b1) begin n_err++; $display("FAIL udf_set got %b want 1", bus.err_udf); end
    n_vec++; if (bus.buf_empty !== 1'b1) begin n_err++; $display("FAIL udf_empty got %b want 1", bus.buf_empty); end
    step(5);
    pushed += 16;
    step(25);
    wa_k++;
    n_vec++; if (bus.buf_empty !== 1'b0) begin n_err++; $display("FAIL udf_no_wrap got %b want 0", bus.buf_empty); end
    c0 = cyc;
    pushed += 16;
    step(19);
    rdone = 1'b1; step(1); rdone = 1'b0;
    wa_k++;
    n_vec++; if (bus.buf_empty !== 1'b0) begin n_err++; $display("FAIL coinc_hold got %b want 0", bus.buf_empty); end
    step(3);
    rdone = 1'b1; step(1); rdone = 1'b0;
    n_vec++; if (bus.buf_empty !== 1'b1) begin n_err++; $display("FAIL coinc_last got %b want 1", bus.buf_empty); end
    n_vec++; if (bus.err_udf !== 1'b1) begin n_err++; $display("FAIL udf_sticky got %b want 1", bus.err_udf); end
    if (cyc < c0) $display("cycle counter went backwards");
    step(2);
  endtask

  task automatic test_fill_full;
    int s0, k0, re_cnt, wr0;
    bit done;
    log_q.delete();
    s0 = popped;
    k0 = wa_k;
    pushed += 16 * 1025;
    done = 1'b0;
    for (int t = 0; t < 25000 && !done; t++) begin
      step(1);
      if (bus.buf_full === 1'b1) done = 1'b1;
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL full_timeout got full %b want 1", bus.buf_full); end
    re_cnt = 0;
    wr0 = log_q.size();
    for (int t = 0; t < 50; t++) begin
      step(1);
      if (bus.fifo_re === 1'b1) re_cnt++;
    end
    n_vec++; if (re_cnt != 0) begin n_err++; $display("FAIL full_re got %0d reads want 0", re_cnt); end
    n_vec++; if (log_q.size() != 16384 || wr0 != 16384) begin n_err++; $display("FAIL full_count got %0d/%0d want 16384", wr0, log_q.size()); end
    rdone = 1'b1; step(1); rdone = 1'b0;
    n_vec++; if (bus.buf_full !== 1'b0) begin n_err++; $display("FAIL full_freed got %b want 0", bus.buf_full); end
    step(40);
    n_vec++; if (log_q.size() != 16400) begin n_err++; $display("FAIL full_refill got %0d want 16400", log_q.size()); end
    n_vec++; if (bus.buf_full !== 1'b1) begin n_err++; $display("FAIL full_again got %b want 1", bus.buf_full); end
    if (log_q.size() == 16400) begin
      n_vec++; if (log_q[(1024 - k0) * 16].wa !== 14'h0000) begin n_err++; $display("FAIL blk1024_wa got %h want 0000", log_q[(1024 - k0) * 16].wa); end
      n_vec++; if (log_q[(1025 - k0) * 16].wa !== 14'h0200) begin n_err++; $display("FAIL blk1025_wa got %h want 0200", log_q[(1025 - k0) * 16].wa); end
      n_vec++; if (log_q[16384].wa !== 14'h0800) begin n_err++; $display("FAIL blk1028_wa got %h want 0800", log_q[16384].wa); end
    end
    for (int i = 0; i < log_q.size(); i++) begin
      n_vec++;
      if (log_q[i].wa !== base(k0 + i / 16) + 14'(i % 16) || log_q[i].wd !== word(s0 + i)) begin
        n_err++;
        $display("FAIL full_wr%0d got wa %h wd %h want wa %h wd %h", i, log_q[i].wa, log_q[i].wd,
                 base(k0 + i / 16) + 14'(i % 16), word(s0 + i));
      end
    end
    wa_k += 1025;
  endtask

  task automatic test_wrap;
    int s0, k0, nblk;
    bit done;
    log_q.delete();
    s0 = popped;
    k0 = wa_k;
    nblk = 2048 - k0 + 1;
    pushed += 16 * nblk;
    done = 1'b0;
    for (int t = 0; t < 25000 && !done; t++) begin
      step(1);
      rdone = !rdone && (bus.buf_empty === 1'b0);
      if (log_q.size() >= 16 * nblk) done = 1'b1;
    end
    rdone = 1'b0;
    n_vec++; if (!done) begin n_err++; $display("FAIL wrap_timeout got %0d writes want %0d", log_q.size(), 16 * nblk); end
    step(30);
    n_vec++; if (log_q.size() != 16 * nblk) begin n_err++; $display("FAIL wrap_count got %0d want %0d", log_q.size(), 16 * nblk); end
    if (log_q.size() == 16 * nblk) begin
      n_vec++; if (log_q[(nblk - 2) * 16].wa !== 14'h3FF0) begin n_err++; $display("FAIL blk2047_wa got %h want 3ff0", log_q[(nblk - 2) * 16].wa); end
      n_vec++; if (log_q[(nblk - 1) * 16].wa !== 14'h0000) begin n_err++; $display("FAIL wrap0_wa got %h want 0000", log_q[(nblk - 1) * 16].wa); end
    end
    for (int i = 0; i < log_q.size(); i++) begin
      n_vec++;
      if (log_q[i].wa !== base(k0 + i / 16) + 14'(i % 16) || log_q[i].wd !== word(s0 + i)) begin
        n_err++;
        $display("FAIL wrap_wr%0d got wa %h wd %h want wa %h wd %h", i, log_q[i].wa, log_q[i].wd,
                 base(k0 + i / 16) + 14'(i % 16), word(s0 + i));
      end
    end
    wa_k = 1;
  endtask

  task automatic test_reset_mid_block;
    int s0;
    bit done;
    log_q.delete();
    pushed += 16;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      step(1);
      if (log_q.size() == 9) done = 1'b1;
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL mid_timeout got %0d writes want 9", log_q.size()); end
    srst = 1'b1;
    #1;
    n_vec++; if (bus.fifo_re   !== 1'b0)  begin n_err++; $display("FAIL mid_fifo_re got %b want 0", bus.fifo_re); end
    n_vec++; if (bus.buf_we    !== 1'b0)  begin n_err++; $display("FAIL mid_buf_we got %b want 0", bus.buf_we); end
    n_vec++; if (bus.buf_wa    !== 14'h0) begin n_err++; $display("FAIL mid_buf_wa got %h want 0", bus.buf_wa); end
    n_vec++; if (bus.buf_wd    !== 64'h0) begin n_err++; $display("FAIL mid_buf_wd got %h want 0", bus.buf_wd); end
    n_vec++; if (bus.buf_empty !== 1'b1)  begin n_err++; $display("FAIL mid_buf_empty got %b want 1", bus.buf_empty); end
    n_vec++; if (bus.buf_full  !== 1'b0)  begin n_err++; $display("FAIL mid_buf_full got %b want 0", bus.buf_full); end
    n_vec++; if (bus.err_udf   !== 1'b0)  begin n_err++; $display("FAIL mid_err_udf got %b want 0", bus.err_udf); end
    step(2);
    pushed = popped;
    srst = 1'b0;
    step(2);
    log_q.delete();
    s0 = popped;
    pushed += 16;
    step(30);
    n_vec++; if (log_q.size() != 16) begin n_err++; $display("FAIL post_rst_count got %0d want 16", log_q.size()); end
    for (int i = 0; i < log_q.size() && i < 16; i++) begin
      n_vec++;
      if (log_q[i].wa !== 14'(i) || log_q[i].wd !== word(s0 + i)) begin
        n_err++;
        $display("FAIL post_rst_wr%0d got wa %h wd %h want wa %h wd %h",
                 i, log_q[i].wa, log_q[i].wd, 14'(i), word(s0 + i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_stall();
    test_counts();
    test_fill_full();
    test_wrap();
    test_reset_mid_block();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
